// File: rtl/vehicle_detector_pkg.sv
// Shared definitions for the side-road vehicle detector and the traffic light controller.
package vehicle_detector_pkg;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b10
    } lamp_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_REQUEST = 2'b01,
        S_SERVING = 2'b10,
        S_FAULT   = 2'b11
    } state_e;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [3:0] CAR_COUNT_MAX = 4'd15;

    // The unused encoding 2'b11 is read as RED so a glitched lamp bus never grants service.
    function automatic lamp_e lamp_decode(input logic [1:0] ew);
        case (ew)
            2'b01:   return YELLOW;
            2'b10:   return GREEN;
            default: return RED;
        endcase
    endfunction

endpackage

// File: rtl/vehicle_detector_sync_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer with a registered rise pulse.
module sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic clear_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differs;
    logic             w_accept;

    assign w_differs = (r_sync2 != r_level);
    assign w_accept  = w_differs && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            // A single matching sample throws away the run collected so far.
            if (!w_differs || w_accept) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept) begin
                r_level <= r_sync2;
            end
            r_rise <= w_accept && r_sync2;
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule

// File: rtl/vehicle_detector.sv
// Side-road vehicle detector: debounced loop sensor, request FSM, queue counter and stuck-sensor guard.
//   state     | meaning
//   S_IDLE    | no request pending, x low
//   S_REQUEST | request latched, x high until side road turns green
//   S_SERVING | side road green, x follows debounced presence
//   S_FAULT   | presence held too long, x and fault high until sensor clears
module vehicle_detector
    import vehicle_detector_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_LIMIT     = 64
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       sensor_raw,
    input  logic [1:0] EW,
    output logic       x,
    output logic [3:0] car_count,
    output logic       fault
);

    localparam int               STUCK_W   = $clog2(STUCK_LIMIT + 1);
    localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_LIMIT);

    logic               w_level;
    logic               w_rise;
    logic               w_green;
    logic               w_stuck_hit;
    logic               w_x_next;
    state_e             r_state;
    state_e             w_next;
    logic               r_x;
    logic               r_fault;
    logic [3:0]         r_car_count;
    logic [STUCK_W-1:0] r_stuck;

    sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sync_debounce (
        .clk    (clk),
        .clear_n(clear_n),
        .raw    (sensor_raw),
        .level  (w_level),
        .rise   (w_rise)
    );

    assign w_green     = (lamp_decode(EW) == GREEN);
    assign w_stuck_hit = (r_stuck == STUCK_MAX) && (r_state != S_FAULT);

    always_comb begin
        w_next   = r_state;
        w_x_next = FALSE;
        case (r_state)
            S_IDLE:    if (w_rise)   w_next = S_REQUEST;
            S_REQUEST: if (w_green)  w_next = S_SERVING;
            S_SERVING: if (!w_green) w_next = w_level ? S_REQUEST : S_IDLE;
            S_FAULT:   if (!w_level) w_next = S_IDLE;
            default:                 w_next = S_IDLE;
        endcase
        if (w_stuck_hit) begin
            w_next = S_FAULT;
        end
        case (w_next)
            S_REQUEST: w_x_next = TRUE;
            S_SERVING: w_x_next = w_level;
            S_FAULT:   w_x_next = TRUE;
            default:   w_x_next = FALSE;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state <= S_IDLE;
            r_x     <= FALSE;
            r_fault <= FALSE;
        end else begin
            r_state <= w_next;
            r_x     <= w_x_next;
            r_fault <= (w_next == S_FAULT);
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_car_count <= '0;
            r_stuck     <= '0;
        end else begin
            // Entering SERVING empties the queue even if a new arrival lands on the same edge.
            if ((w_next == S_SERVING) && (r_state != S_SERVING)) begin
                r_car_count <= '0;
            end else if (w_rise && (r_car_count != CAR_COUNT_MAX)) begin
                r_car_count <= r_car_count + 1'b1;
            end
            if (!w_level) begin
                r_stuck <= '0;
            end else if (r_stuck != STUCK_MAX) begin
                r_stuck <= r_stuck + 1'b1;
            end
        end
    end

    assign x         = r_x;
    assign fault     = r_fault;
    assign car_count = r_car_count;

endmodule

// File: tb/tb_vehicle_detector.sv
// Scoreboard-driven bench for vehicle_detector at default parameters.
module tb_vehicle_detector;
    import vehicle_detector_pkg::*;

    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic       sensor_raw = 1'b0;
    logic [1:0] EW = 2'b00;
    logic       x;
    logic [3:0] car_count;
    logic       fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic       ex;
        logic [3:0] cnt;
        logic       flt;
    } exp_t;

    exp_t sb[$];

    vehicle_detector dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .sensor_raw(sensor_raw),
        .EW        (EW),
        .x         (x),
        .car_count (car_count),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        clear_n    = 1'b0;
        sensor_raw = 1'b0;
        EW         = RED;
        repeat (2) @(negedge clk);
        clear_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        clear_n = 1'b0;
        #1;
        sb.push_back('{"reset_now", 1'b0, 4'd0, 1'b0});
        e = sb.pop_front();
        checks++;
        if ({x, car_count, fault} !== {e.ex, e.cnt, e.flt}) begin
            errors++;
            $display("FAIL %s: got x=%0b car_count=%0d fault=%0b, expected x=%0b car_count=%0d fault=%0b",
                     e.tag, x, car_count, fault, e.ex, e.cnt, e.flt);
        end
        sensor_raw = 1'b1;
        EW         = GREEN;
        sb.push_back('{"reset_held", 1'b0, 4'd0, 1'b0});
        tick(12);
        e = sb.pop_front();
        checks++;
        if ({x, car_count, fault} !== {e.ex, e.cnt, e.flt}) begin
            errors++;
            $display("FAIL %s: got x=%0b car_count=%0d fault=%0b, expected x=%0b car_count=%0d fault=%0b",
                     e.tag, x, car_count, fault, e.ex, e.cnt, e.flt);
        end
    endtask

    task automatic test_latency();
        exp_t e;
        apply_reset();
        sensor_raw = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            sb.push_back('{$sformatf("latency_edge%0d", k), (k == 7), ((k == 7) ? 4'd1 : 4'd0), 1'b0});
            tick(1);
            e = sb.pop_front();
            checks++;
            if ({x, car_count, fault} !== {e.ex, e.cnt, e.flt}) begin
                errors++;
                $display("FAIL %s: got x=%0b car_count=%0d fault=%0b, expected x=%0b car_count=%0d fault=%0b",
                         e.tag, x, car_count, fault, e.ex, e.cnt, e.flt);
            end
        end
    endtask

    task automatic test_bounce();
        exp_t e;
        apply_reset();
        sensor_raw = 1'b1;
        tick(3);
        sensor_raw = 1'b0;
        for (int k = 4; k <= 15; k++) begin
            sb.push_back('{$sformatf("bounce3_edge%0d", k), 1'b0, 4'd0, 1'b0});
            tick(1);
            e = sb.pop_front();
            checks++;
            if ({x, car_count, fault} !== {e.ex, e.cnt, e.flt}) begin
                errors++;
                $display("FAIL %s: got x=%0b car_count=%0d fault=%0b, expected x=%0b car_count=%0d fault=%0b",
                         e.tag, x, car_count, fault, e.ex, e.cnt, e.flt);
            end
        end
        // Four high samples is the shortest pulse that must be accepted.
        sensor_raw = 1'b1;
        tick(4);
        sensor_raw = 1'b0;
        for (int k = 5; k <= 7; k++) begin
            sb.push_back('{$sformatf("pulse4_edge%0d", k), (k == 7), ((k == 7) ? 4'd1 : 4'd0), 1'b0});
            tick(1);
            e = sb.pop_front();
            checks++;
            if ({x, car_count, fault} !== {e.ex, e.cnt, e.flt}) begin
                errors++;
                $display("FAIL %s: got x=%0b car_count=%0d fault=%0b, expected x=%0b car_count=%0d fault=%0b",
                         e.tag, x, car_count, fault, e.ex, e.cnt, e.flt);
            end
        end
    endtask

    task automatic test_request_latch();
        exp_t e;
        exp_t plan[$];
        apply_reset();
        sensor_raw = 1'b1;
        plan.push_back('{"req_rise",      1'b1, 4'd1, 1'b0});
        plan.push_back('{"req_latched",   1'b1, 4'd1, 1'b0});
        plan.push_back('{"illegal_ew",    1'b1, 4'd1, 1'b0});
        plan.push_back('{"serving",       1'b0, 4'd0, 1'b0});
        plan.push_back('{"yellow_idle",   1'b0, 4'd0, 1'b0});
        plan.push_back('{"green_in_idle", 1'b0, 4'd0, 1'b0});
        plan.push_back('{"re_arrival",    1'b1, 4'd1, 1'b0});
        for (int step = 0; step < plan.size(); step++) begin
            sb.push_back(plan[step]);
            case (step)
                0: tick(7);
                1: begin sensor_raw = 1'b0; tick(10); end
                2: begin EW = 2'b11; tick(3); end
                3: begin EW = GREEN; tick(1); end
                4: begin EW = YELLOW; tick(1); end
                5: begin EW = GREEN; tick(3); end
                default: begin EW = RED; sensor_raw = 1'b1; tick(7); end
            endcase
            e = sb.pop_front();
            checks++;
            if ({x, car_count, fault} !== {e.ex, e.cnt, e.flt}) begin
                errors++;
                $display("FAIL %s: got x=%0b car_count=%0d fault=%0b, expected x=%0b car_count=%0d fault=%0b",
                         e.tag, x, car_count, fault, e.ex, e.cnt, e.flt);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        apply_reset();
        sensor_raw = 1'b1;
        for (int step = 0; step < 4; step++) begin
            case (step)
                0: begin sb.push_back('{"b2b_request", 1'b1, 4'd1, 1'b0}); tick(7); end
                1: begin sb.push_back('{"b2b_serve_present", 1'b1, 4'd0, 1'b0}); EW = GREEN; tick(1); end
                2: begin sb.push_back('{"b2b_back_to_request", 1'b1, 4'd0, 1'b0}); EW = RED; tick(1); end
                default: begin
                    sb.push_back('{"b2b_still_latched", 1'b1, 4'd0, 1'b0});
                    sensor_raw = 1'b0;
                    tick(10);
                end
            endcase
            e = sb.pop_front();
            checks++;
            if ({x, car_count, fault} !== {e.ex, e.cnt, e.flt}) begin
                errors++;
                $display("FAIL %s: got x=%0b car_count=%0d fault=%0b, expected x=%0b car_count=%0d fault=%0b",
                         e.tag, x, car_count, fault, e.ex, e.cnt, e.flt);
            end
        end
    endtask

    task automatic test_fault();
        exp_t e;
        apply_reset();
        sensor_raw = 1'b1;
        for (int step = 0; step < 4; step++) begin
            case (step)
                0: begin sb.push_back('{"pre_fault_edge70", 1'b1, 4'd1, 1'b0}); tick(70); end
                1: begin sb.push_back('{"fault_edge71", 1'b1, 4'd1, 1'b1}); tick(1); end
                2: begin
                    sb.push_back('{"fault_hold", 1'b1, 4'd1, 1'b1});
                    EW = GREEN;
                    sensor_raw = 1'b0;
                    tick(6);
                end
                default: begin sb.push_back('{"fault_clear", 1'b0, 4'd1, 1'b0}); tick(1); end
            endcase
            e = sb.pop_front();
            checks++;
            if ({x, car_count, fault} !== {e.ex, e.cnt, e.flt}) begin
                errors++;
                $display("FAIL %s: got x=%0b car_count=%0d fault=%0b, expected x=%0b car_count=%0d fault=%0b",
                         e.tag, x, car_count, fault, e.ex, e.cnt, e.flt);
            end
        end
        EW = RED;
    endtask

    task automatic test_saturate();
        exp_t e;
        int   model_cnt;
        model_cnt = 0;
        apply_reset();
        for (int i = 1; i <= 16; i++) begin
            model_cnt = (model_cnt < 15) ? model_cnt + 1 : 15;
            sb.push_back('{$sformatf("arrival%0d", i), 1'b1, 4'(model_cnt), 1'b0});
            sensor_raw = 1'b1;
            tick(7);
            sensor_raw = 1'b0;
            tick(7);
            e = sb.pop_front();
            checks++;
            if ({x, car_count, fault} !== {e.ex, e.cnt, e.flt}) begin
                errors++;
                $display("FAIL %s: got x=%0b car_count=%0d fault=%0b, expected x=%0b car_count=%0d fault=%0b",
                         e.tag, x, car_count, fault, e.ex, e.cnt, e.flt);
            end
        end
    endtask

    task automatic test_reset_mid_request();
        exp_t e;
        apply_reset();
        sensor_raw = 1'b1;
        sb.push_back('{"pre_clear", 1'b1, 4'd1, 1'b0});
        tick(7);
        e = sb.pop_front();
        checks++;
        if ({x, car_count, fault} !== {e.ex, e.cnt, e.flt}) begin
            errors++;
            $display("FAIL %s: got x=%0b car_count=%0d fault=%0b, expected x=%0b car_count=%0d fault=%0b",
                     e.tag, x, car_count, fault, e.ex, e.cnt, e.flt);
        end
        #2;
        clear_n = 1'b0;
        sb.push_back('{"async_clear_request", 1'b0, 4'd0, 1'b0});
        #1;
        e = sb.pop_front();
        checks++;
        if ({x, car_count, fault} !== {e.ex, e.cnt, e.flt}) begin
            errors++;
            $display("FAIL %s: got x=%0b car_count=%0d fault=%0b, expected x=%0b car_count=%0d fault=%0b",
                     e.tag, x, car_count, fault, e.ex, e.cnt, e.flt);
        end
        repeat (2) @(negedge clk);
        clear_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            sb.push_back('{$sformatf("re_request_edge%0d", k), (k == 7), ((k == 7) ? 4'd1 : 4'd0), 1'b0});
            tick(1);
            e = sb.pop_front();
            checks++;
            if ({x, car_count, fault} !== {e.ex, e.cnt, e.flt}) begin
                errors++;
                $display("FAIL %s: got x=%0b car_count=%0d fault=%0b, expected x=%0b car_count=%0d fault=%0b",
                         e.tag, x, car_count, fault, e.ex, e.cnt, e.flt);
            end
        end
    endtask

    task automatic test_reset_mid_fault();
        exp_t e;
        apply_reset();
        sensor_raw = 1'b1;
        sb.push_back('{"fault_before_clear", 1'b1, 4'd1, 1'b1});
        tick(71);
        e = sb.pop_front();
        checks++;
        if ({x, car_count, fault} !== {e.ex, e.cnt, e.flt}) begin
            errors++;
            $display("FAIL %s: got x=%0b car_count=%0d fault=%0b, expected x=%0b car_count=%0d fault=%0b",
                     e.tag, x, car_count, fault, e.ex, e.cnt, e.flt);
        end
        #2;
        clear_n = 1'b0;
        sb.push_back('{"async_clear_fault", 1'b0, 4'd0, 1'b0});
        #1;
        e = sb.pop_front();
        checks++;
        if ({x, car_count, fault} !== {e.ex, e.cnt, e.flt}) begin
            errors++;
            $display("FAIL %s: got x=%0b car_count=%0d fault=%0b, expected x=%0b car_count=%0d fault=%0b",
                     e.tag, x, car_count, fault, e.ex, e.cnt, e.flt);
        end
        repeat (2) @(negedge clk);
        clear_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_bounce();
        test_request_latch();
        test_back_to_back();
        test_fault();
        test_saturate();
        test_reset_mid_request();
        test_reset_mid_fault();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vehicle_detector.md
VEHICLE_DETECTOR -- requirements
Module: vehicle_detector

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized samples required to accept a sensor level change.
REQ-002 Parameter STUCK_LIMIT, default 64: cycles of continuous debounced presence after which the sensor is declared faulty.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 clear_n  input  1  reset; the block has one clock, and reset is asynchronous and active-low.
REQ-005 sensor_raw  input  1  raw side-road loop detector; asynchronous to clk and may bounce.
REQ-006 EW  input  2  current side-road lamp state from the traffic light controller (package encoding).
REQ-007 x  output  1  registered side-road vehicle request to the traffic light controller.
REQ-008 car_count  output  4  vehicles queued since last side-road green; saturating.
REQ-009 fault  output  1  registered stuck-sensor indication.

Function
REQ-010 sensor_raw SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 The debounced level SHALL change only after DEBOUNCE_CYCLES consecutive synchronized samples differ from it; any mismatch-free gap restarts the count.
REQ-012 Raw-to-x latency: x SHALL rise on the DEBOUNCE_CYCLES+3rd rising edge after sensor_raw is first sampled high and held (7 edges at defaults), when in IDLE.
REQ-013 FSM states: IDLE, REQUEST, SERVING, FAULT; state and outputs are registered.
REQ-014 IDLE: x=0; debounced rising edge -> REQUEST.
REQ-015 REQUEST: x=1 regardless of presence (request is latched); EW==GREEN -> SERVING.
REQ-016 SERVING: x = debounced presence; EW!=GREEN -> REQUEST if presence is 1, else IDLE.
REQ-017 Any state except FAULT: continuous debounced presence reaching STUCK_LIMIT cycles -> FAULT (takes priority over other transitions that cycle).
REQ-018 FAULT: fault=1, x=1; debounced presence falling -> IDLE with fault=0 on the same edge as the transition.
REQ-019 car_count SHALL increment on each debounced rising edge, saturate at 15, and clear to 0 on entry to SERVING; clear wins over a simultaneous increment.
REQ-020 An EW value of GREEN seen in IDLE SHALL be ignored.
REQ-021 An illegal EW encoding SHALL be treated as RED.
REQ-022 The stuck counter SHALL saturate at STUCK_LIMIT and reset to 0 whenever debounced presence is 0.

Reset
REQ-023 clear_n low SHALL asynchronously force: state=IDLE, x=0, fault=0, car_count=0, synchronizer flops=0, debounced level=0, all counters=0.
REQ-024 Reset asserted mid-request or mid-FAULT SHALL abandon the request; after release, a still-present vehicle SHALL re-request with full REQ-012 latency.

Structure
REQ-025 A shared package SHALL hold the lamp encoding (RED=2'b00, YELLOW=2'b01, GREEN=2'b10), the FSM state enum, and the TRUE/FALSE constants used by this block and the traffic light controller.
REQ-026 The synchronizer and debouncer SHALL be a sub-module named sync_debounce (inputs clk, clear_n, raw; output level, rise pulse).
REQ-027 vehicle_detector output x SHALL connect directly to the controller's x input with no further logic.

Verification
REQ-028 Reset release, sensor_raw=1 held, EW=RED -> x=0 for 6 edges, x=1 at edge 7, car_count=1.
REQ-029 sensor_raw high-pulse of 3 cycles, then low -> x stays 0, car_count stays 0 (rejected bounce).
REQ-030 Vehicle arrives and leaves during REQUEST (EW=RED) -> x remains 1; EW=GREEN -> SERVING, x=0, car_count=0; EW=YELLOW -> IDLE.
REQ-031 Presence held 64+ cycles with EW=RED -> fault=1, x=1; sensor_raw low for 4+ cycles -> fault=0, x=0, state IDLE.
REQ-032 Sixteen debounced arrivals without EW=GREEN -> car_count=15 (saturated).
REQ-033 clear_n pulsed low during REQUEST -> x=0 immediately (asynchronous); held presence re-asserts x 7 edges after release.
